// File: rtl/axi4_lite_write_arbiter.sv
// Two-to-one AXI4-Lite write-channel arbiter. Round-robin grant taken in IDLE,
// AW/W forwarded in ADDR, B routed back in RESP; one write outstanding at a time.
module axi4_lite_write_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  // Upstream write master 0
  input  logic [ADDR_WIDTH-1:0]   S0_AW_ADDR,
  input  logic                    S0_AW_VALID,
  output logic                    S0_AW_READY,
  input  logic [DATA_WIDTH-1:0]   S0_W_DATA,
  input  logic [DATA_WIDTH/8-1:0] S0_WSTRB,
  input  logic                    S0_W_VALID,
  output logic                    S0_W_READY,
  output logic [1:0]              S0_B_RESP,
  output logic                    S0_B_VALID,
  input  logic                    S0_B_READY,
  // Upstream write master 1
  input  logic [ADDR_WIDTH-1:0]   S1_AW_ADDR,
  input  logic                    S1_AW_VALID,
  output logic                    S1_AW_READY,
  input  logic [DATA_WIDTH-1:0]   S1_W_DATA,
  input  logic [DATA_WIDTH/8-1:0] S1_WSTRB,
  input  logic                    S1_W_VALID,
  output logic                    S1_W_READY,
  output logic [1:0]              S1_B_RESP,
  output logic                    S1_B_VALID,
  input  logic                    S1_B_READY,
  // Downstream write slave
  output logic [ADDR_WIDTH-1:0]   M_AW_ADDR,
  output logic                    M_AW_VALID,
  input  logic                    M_AW_READY,
  output logic [DATA_WIDTH-1:0]   M_W_DATA,
  output logic [DATA_WIDTH/8-1:0] M_WSTRB,
  output logic                    M_W_VALID,
  input  logic                    M_W_READY,
  input  logic [1:0]              M_B_RESP,
  input  logic                    M_B_VALID,
  output logic                    M_B_READY
);

  typedef enum logic [1:0] {StIdle, StAddr, StResp} state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_q, last_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  logic                    sel_aw_valid;
  logic [ADDR_WIDTH-1:0]   sel_aw_addr;
  logic                    sel_w_valid;
  logic [DATA_WIDTH-1:0]   sel_w_data;
  logic [DATA_WIDTH/8-1:0] sel_wstrb;
  logic                    sel_b_ready;
  logic                    aw_ready;
  logic                    w_ready;
  logic                    b_valid;
  logic [1:0]              b_resp;

  // Select the granted master's request-side signals
  always_comb begin
    sel_aw_valid = grant_q ? S1_AW_VALID : S0_AW_VALID;
    sel_aw_addr  = grant_q ? S1_AW_ADDR  : S0_AW_ADDR;
    sel_w_valid  = grant_q ? S1_W_VALID  : S0_W_VALID;
    sel_w_data   = grant_q ? S1_W_DATA   : S0_W_DATA;
    sel_wstrb    = grant_q ? S1_WSTRB    : S0_WSTRB;
    sel_b_ready  = grant_q ? S1_B_READY  : S0_B_READY;
  end

  // Channel forwarding; everything is held at zero outside the state that owns it
  always_comb begin
    M_AW_ADDR  = '0;
    M_AW_VALID = 1'b0;
    M_W_DATA   = '0;
    M_WSTRB    = '0;
    M_W_VALID  = 1'b0;
    M_B_READY  = 1'b0;
    aw_ready   = 1'b0;
    w_ready    = 1'b0;
    b_valid    = 1'b0;
    b_resp     = 2'b00;
    unique case (state_q)
      StAddr: begin
        // Done flags mask a channel once its beat has gone through
        M_AW_ADDR  = sel_aw_addr;
        M_AW_VALID = sel_aw_valid & ~aw_done_q;
        aw_ready   = M_AW_READY & ~aw_done_q;
        M_W_DATA   = sel_w_data;
        M_WSTRB    = sel_wstrb;
        M_W_VALID  = sel_w_valid & ~w_done_q;
        w_ready    = M_W_READY & ~w_done_q;
      end
      StResp: begin
        b_valid   = M_B_VALID;
        b_resp    = M_B_RESP;
        M_B_READY = sel_b_ready;
      end
      default: ;
    endcase
  end

  // Steer the upstream-facing handshakes to the granted port only
  always_comb begin
    S0_AW_READY = ~grant_q & aw_ready;
    S0_W_READY  = ~grant_q & w_ready;
    S0_B_VALID  = ~grant_q & b_valid;
    S0_B_RESP   = grant_q ? 2'b00 : b_resp;
    S1_AW_READY = grant_q & aw_ready;
    S1_W_READY  = grant_q & w_ready;
    S1_B_VALID  = grant_q & b_valid;
    S1_B_RESP   = grant_q ? b_resp : 2'b00;
  end

  // Next-state: registered round-robin arbitration and handshake tracking
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      StIdle: begin
        if (S0_AW_VALID || S1_AW_VALID) begin
          // On contention the port that did not win last time goes next
          if (S0_AW_VALID && S1_AW_VALID) grant_d = ~last_q;
          else                            grant_d = S1_AW_VALID;
          state_d   = StAddr;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      StAddr: begin
        aw_done_d = aw_done_q | (M_AW_VALID & M_AW_READY);
        w_done_d  = w_done_q  | (M_W_VALID & M_W_READY);
        if (aw_done_d && w_done_d) state_d = StResp;
      end
      StResp: begin
        if (M_B_VALID && M_B_READY) begin
          last_d  = grant_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset drops any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_write_arbiter.sv
// Bench for axi4_lite_write_arbiter: table of contended writes plus directed
// sequences, with a queue of expected downstream beats checked by a monitor.
module tb_axi4_lite_write_arbiter;

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  logic [31:0] s_aw_addr [2];
  logic [31:0] s_w_data  [2];
  logic [3:0]  s_wstrb   [2];
  logic [1:0]  s_aw_valid;
  logic [1:0]  s_w_valid;
  logic [1:0]  s_b_ready;
  wire  [1:0]  s_aw_ready;
  wire  [1:0]  s_w_ready;
  wire  [1:0]  s_b_valid;
  wire  [1:0]  s0_b_resp;
  wire  [1:0]  s1_b_resp;

  wire  [31:0] m_aw_addr;
  wire         m_aw_valid;
  logic        m_aw_ready;
  wire  [31:0] m_w_data;
  wire  [3:0]  m_wstrb;
  wire         m_w_valid;
  wire         m_w_ready;
  logic [1:0]  m_b_resp;
  logic        m_b_valid;
  wire         m_b_ready;

  // Slave model knobs and state
  int          w_stall;
  logic [1:0]  slv_resp;
  int          stall_cnt;
  logic        aw_seen;
  logic        w_seen;
  logic [31:0] slv_addr;

  // Scoreboard and monitor state
  vec_t        exp_q[$];
  vec_t        vecs[8];
  int          total;
  int          bad;
  int          cyc;
  int          last_b;
  int          aw_cnt;
  int          w_cnt;
  int          b_cnt;
  bit          gap_en;
  bit          gap_armed;
  bit          have_aw;
  bit          have_w;
  logic        aw_prev;
  logic [31:0] cur_addr;
  logic [31:0] cur_data;
  logic [3:0]  cur_strb;

  wire [80:0] all_out = {s_aw_ready, s_w_ready, s_b_valid, s0_b_resp, s1_b_resp, m_aw_addr,
                         m_aw_valid, m_w_data, m_wstrb, m_w_valid, m_b_ready};

  axi4_lite_write_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .S0_AW_ADDR (s_aw_addr[0]),
    .S0_AW_VALID(s_aw_valid[0]),
    .S0_AW_READY(s_aw_ready[0]),
    .S0_W_DATA  (s_w_data[0]),
    .S0_WSTRB   (s_wstrb[0]),
    .S0_W_VALID (s_w_valid[0]),
    .S0_W_READY (s_w_ready[0]),
    .S0_B_RESP  (s0_b_resp),
    .S0_B_VALID (s_b_valid[0]),
    .S0_B_READY (s_b_ready[0]),
    .S1_AW_ADDR (s_aw_addr[1]),
    .S1_AW_VALID(s_aw_valid[1]),
    .S1_AW_READY(s_aw_ready[1]),
    .S1_W_DATA  (s_w_data[1]),
    .S1_WSTRB   (s_wstrb[1]),
    .S1_W_VALID (s_w_valid[1]),
    .S1_W_READY (s_w_ready[1]),
    .S1_B_RESP  (s1_b_resp),
    .S1_B_VALID (s_b_valid[1]),
    .S1_B_READY (s_b_ready[1]),
    .M_AW_ADDR  (m_aw_addr),
    .M_AW_VALID (m_aw_valid),
    .M_AW_READY (m_aw_ready),
    .M_W_DATA   (m_w_data),
    .M_WSTRB    (m_wstrb),
    .M_W_VALID  (m_w_valid),
    .M_W_READY  (m_w_ready),
    .M_B_RESP   (m_b_resp),
    .M_B_VALID  (m_b_valid),
    .M_B_READY  (m_b_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required earlier finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] b_resp_of(input int p);
    return (p == 1) ? s1_b_resp : s0_b_resp;
  endfunction

  // Slave: AW always ready, optional W stall after AW, B raised on the edge that
  // completes both beats; response is slv_resp xor addr[3:2] so routing is visible
  assign m_w_ready = (w_stall == 0) || (aw_seen && stall_cnt == 0);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_seen   <= 1'b0;
      w_seen    <= 1'b0;
      stall_cnt <= 0;
      m_b_valid <= 1'b0;
      m_b_resp  <= 2'b00;
      slv_addr  <= '0;
    end else begin
      if (m_b_valid && m_b_ready) m_b_valid <= 1'b0;
      if (stall_cnt > 0) stall_cnt <= stall_cnt - 1;
      if (m_aw_valid && m_aw_ready) begin
        aw_seen   <= 1'b1;
        slv_addr  <= m_aw_addr;
        stall_cnt <= w_stall;
      end
      if (m_w_valid && m_w_ready) w_seen <= 1'b1;
      if ((aw_seen || (m_aw_valid && m_aw_ready)) && (w_seen || (m_w_valid && m_w_ready)) &&
          !m_b_valid) begin
        m_b_valid <= 1'b1;
        m_b_resp  <= slv_resp ^ (aw_seen ? slv_addr[3:2] : m_aw_addr[3:2]);
        aw_seen   <= 1'b0;
        w_seen    <= 1'b0;
      end
    end
  end

  // Monitor: pairs each AW/W beat with the next expected record, tracks the
  // B-to-next-AW gap and handshake counts
  always @(negedge clk) begin
    if (reset) begin
      have_aw = 1'b0;
      have_w  = 1'b0;
      aw_prev = 1'b0;
    end else begin
      if (m_aw_valid && m_aw_ready) begin
        cur_addr = m_aw_addr;
        have_aw  = 1'b1;
        aw_cnt++;
      end
      if (m_w_valid && m_w_ready) begin
        cur_data = m_w_data;
        cur_strb = m_wstrb;
        have_w   = 1'b1;
        w_cnt++;
      end
      if (have_aw && have_w) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got write addr 0x%0h, required none", cur_addr);
        end else begin
          vec_t e;
          e = exp_q.pop_front();
          chk("sb_addr", cur_addr, e.addr);
          chk("sb_data", cur_data, e.data);
          chk("sb_strb", cur_strb, e.strb);
        end
        have_aw = 1'b0;
        have_w  = 1'b0;
      end
      if (m_aw_valid && !aw_prev) begin
        if (gap_en && gap_armed) chk("b_to_next_aw_gap", cyc - last_b, 2);
        gap_armed = 1'b0;
      end
      if (m_b_valid && m_b_ready) begin
        b_cnt++;
        last_b    = cyc;
        gap_armed = 1'b1;
      end
      aw_prev = m_aw_valid;
    end
  end

  // One upstream write: hold AW/W until each handshakes, then take B after
  // bdelay cycles of B_VALID; hold_aw keeps AW_VALID up until B completes
  task automatic master_write(input int p, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int bdelay, input bit hold_aw);
    bit aw_pend, w_pend, aw_hs, w_hs, done;
    int n, cnt;
    s_aw_addr[p]  = addr;
    s_w_data[p]   = data;
    s_wstrb[p]    = strb;
    s_aw_valid[p] = 1'b1;
    s_w_valid[p]  = 1'b1;
    aw_pend = 1'b1;
    w_pend  = 1'b1;
    n = 0;
    while ((aw_pend || w_pend) && n < 60) begin
      @(negedge clk);
      n++;
      aw_hs = aw_pend && s_aw_ready[p];
      w_hs  = w_pend && s_w_ready[p];
      @(posedge clk);
      #1;
      if (aw_hs) begin
        aw_pend = 1'b0;
        if (!hold_aw) s_aw_valid[p] = 1'b0;
      end
      if (w_hs) begin
        w_pend = 1'b0;
        s_w_valid[p] = 1'b0;
      end
    end
    chk($sformatf("s%0d_aw_w_pending", p), {aw_pend, w_pend}, 2'b00);
    done = 1'b0;
    cnt = 0;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (s_b_valid[p]) begin
        if (cnt < bdelay) begin
          chk($sformatf("s%0d_m_b_ready_held", p), m_b_ready, 1'b0);
          cnt++;
        end else begin
          s_b_ready[p] = 1'b1;
          #1;
          chk($sformatf("s%0d_b_resp", p), b_resp_of(p), slv_resp ^ addr[3:2]);
          chk($sformatf("s%0d_other_b_valid", p), s_b_valid[1-p], 1'b0);
          @(posedge clk);
          #1;
          s_b_ready[p]  = 1'b0;
          s_aw_valid[p] = 1'b0;
          done = 1'b1;
        end
      end
    end
    chk($sformatf("s%0d_b_received", p), done, 1'b1);
  endtask

  task automatic push_exp(input int p, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    vec_t e;
    e.port = p;
    e.addr = addr;
    e.data = data;
    e.strb = strb;
    exp_q.push_back(e);
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    aw_cnt = 0;
    w_cnt = 0;
    b_cnt = 0;
    gap_en = 1'b0;
    gap_armed = 1'b0;
    w_stall = 0;
    slv_resp = 2'b00;
    m_aw_ready = 1'b1;
    s_aw_valid = '0;
    s_w_valid = '0;
    s_b_ready = '0;
    for (int i = 0; i < 2; i++) begin
      s_aw_addr[i] = '0;
      s_w_data[i]  = '0;
      s_wstrb[i]   = '0;
    end
    // Contention table, in the order the downstream port must see the writes
    vecs[0] = '{port: 0, addr: 32'h100, data: 32'hA000_0000, strb: 4'hF};
    vecs[1] = '{port: 1, addr: 32'h200, data: 32'hB000_0000, strb: 4'h3};
    vecs[2] = '{port: 0, addr: 32'h104, data: 32'hA000_0001, strb: 4'hC};
    vecs[3] = '{port: 1, addr: 32'h204, data: 32'hB000_0001, strb: 4'h1};
    vecs[4] = '{port: 0, addr: 32'h108, data: 32'hA000_0002, strb: 4'hF};
    vecs[5] = '{port: 1, addr: 32'h208, data: 32'hB000_0002, strb: 4'h8};
    vecs[6] = '{port: 0, addr: 32'h10C, data: 32'hA000_0003, strb: 4'h6};
    vecs[7] = '{port: 1, addr: 32'h20C, data: 32'hB000_0003, strb: 4'hF};

    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", all_out, '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_outputs", all_out, '0);

    // Single S0 write with exact latency
    @(posedge clk);
    #1;
    push_exp(0, 32'h10, 32'hDEADBEEF, 4'hF);
    fork
      master_write(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
      begin
        @(negedge clk);
        chk("single_no_comb_aw", m_aw_valid, 1'b0);
        @(negedge clk);
        chk("single_aw_valid_n1", m_aw_valid, 1'b1);
        chk("single_aw_addr", m_aw_addr, 32'h10);
        chk("single_w_data", m_w_data, 32'hDEADBEEF);
        chk("single_wstrb", m_wstrb, 4'hF);
        @(negedge clk);
        chk("single_b_valid_n2", s_b_valid, 2'b01);
        chk("single_b_resp", s0_b_resp, 2'b00);
      end
    join

    // Late request: S1 arrives while S0 sits in RESP
    gap_en = 1'b1;
    gap_armed = 1'b0;
    @(posedge clk);
    #1;
    push_exp(0, 32'h500, 32'h5555_0000, 4'hF);
    push_exp(1, 32'h600, 32'h6666_0000, 4'h5);
    fork
      master_write(0, 32'h500, 32'h5555_0000, 4'hF, 2, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1;
        master_write(1, 32'h600, 32'h6666_0000, 4'h5, 0, 1'b0);
      end
    join
    chk("late_queue_empty", exp_q.size(), 0);

    // Contention: both masters stream 4 writes each
    gap_armed = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) exp_q.push_back(vecs[i]);
    fork
      begin
        for (int i = 0; i < 8; i++)
          if (vecs[i].port == 0) master_write(0, vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 1'b0);
      end
      begin
        for (int j = 0; j < 8; j++)
          if (vecs[j].port == 1) master_write(1, vecs[j].addr, vecs[j].data, vecs[j].strb, 0, 1'b0);
      end
    join
    chk("contention_queue_empty", exp_q.size(), 0);

    // Split handshakes: W stalled 3 cycles after AW, AW_VALID kept high
    gap_en = 1'b0;
    w_stall = 3;
    @(posedge clk);
    #1;
    aw_cnt = 0;
    w_cnt = 0;
    b_cnt = 0;
    push_exp(0, 32'h40, 32'h1234_5678, 4'hA);
    master_write(0, 32'h40, 32'h1234_5678, 4'hA, 0, 1'b1);
    repeat (2) @(negedge clk);
    chk("split_aw_count", aw_cnt, 1);
    chk("split_w_count", w_cnt, 1);
    chk("split_b_count", b_cnt, 1);
    w_stall = 0;

    // Backpressured SLVERR to S1 with S0 pending
    gap_en = 1'b1;
    gap_armed = 1'b0;
    slv_resp = 2'b10;
    @(posedge clk);
    #1;
    push_exp(1, 32'h300, 32'h3333_0000, 4'hF);
    push_exp(0, 32'h400, 32'h4444_0000, 4'hF);
    fork
      master_write(1, 32'h300, 32'h3333_0000, 4'hF, 5, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1;
        master_write(0, 32'h400, 32'h4444_0000, 4'hF, 0, 1'b0);
      end
    join
    chk("bp_queue_empty", exp_q.size(), 0);
    slv_resp = 2'b00;

    // Reset mid-ADDR with S1 granted and its AW already taken
    gap_en = 1'b0;
    w_stall = 3;
    @(posedge clk);
    #1;
    s_aw_addr[1]  = 32'h700;
    s_w_data[1]   = 32'h7777_0000;
    s_wstrb[1]    = 4'hF;
    s_aw_valid[1] = 1'b1;
    s_w_valid[1]  = 1'b1;
    s_b_ready[1]  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    s_aw_valid[1] = 1'b0;
    @(negedge clk);
    chk("rst_mid_aw_done_mask", m_aw_valid, 1'b0);
    chk("rst_mid_w_stalled", s_w_ready, 2'b00);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_outputs_async", all_out, '0);
    s_w_valid[1] = 1'b0;
    w_stall = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_mid_no_b", s_b_valid, 2'b00);
    end
    reset = 1'b0;
    s_b_ready[1] = 1'b0;
    @(negedge clk);
    chk("rst_release_no_b", {s_b_valid, m_b_valid}, 3'b000);
    gap_en = 1'b1;
    gap_armed = 1'b0;
    @(posedge clk);
    #1;
    push_exp(0, 32'h800, 32'h8888_0000, 4'hF);
    push_exp(1, 32'h900, 32'h9999_0000, 4'hF);
    fork
      master_write(0, 32'h800, 32'h8888_0000, 4'hF, 0, 1'b0);
      master_write(1, 32'h900, 32'h9999_0000, 4'hF, 0, 1'b0);
    join
    chk("post_reset_queue_empty", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
